// File: rtl/prf_batch_scheduler.sv
// Batch sequencer for a single PRF evaluation core: issues one start per index,
// waits for done (with watchdog), and streams each result out with back-pressure.
module prf_batch_scheduler #(
    parameter int P              = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1),
    localparam int OUT_WIDTH     = $clog2(P)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [63:0]          req_nonce,
    input  logic [63:0]          req_base,
    input  logic [CNT_WIDTH-1:0] req_count,
    output logic                 core_start,
    output logic [63:0]          core_nonce,
    output logic [63:0]          core_index,
    input  logic                 core_done,
    input  logic [OUT_WIDTH-1:0] core_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [63:0]          out_index,
    output logic                 out_last,
    output logic                 out_err,
    output logic                 busy
);

    // A disabled watchdog still needs a legal one-bit counter.
    localparam int WD_W = (TO_WIDTH < 1) ? 1 : TO_WIDTH;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [63:0]            nonce_q, nonce_d;
    logic [63:0]            index_q, index_d;
    logic [CNT_WIDTH-1:0]   rem_q, rem_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   core_start_q, core_start_d;
    logic                   out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic [63:0]            out_index_q, out_index_d;
    logic                   out_last_q, out_last_d;
    logic                   out_err_q, out_err_d;

    always_comb begin
        state_d      = state_q;
        nonce_d      = nonce_q;
        index_d      = index_q;
        rem_d        = rem_q;
        wd_d         = wd_q;
        core_start_d = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_index_d  = out_index_q;
        out_last_d   = out_last_q;
        out_err_d    = out_err_q;

        case (state_q)
            S_IDLE: begin
                // A zero-count request is consumed here without any side effect.
                if (req_valid && (req_count != '0)) begin
                    nonce_d      = req_nonce;
                    index_d      = req_base;
                    rem_d        = req_count;
                    core_start_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (core_done) begin
                    out_data_d  = core_out;
                    out_index_d = index_q;
                    out_last_d  = (rem_q == CNT_WIDTH'(1));
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_OUTPUT;
                end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
                    // A hung core terminates the whole batch with one error beat.
                    out_data_d  = '0;
                    out_index_d = index_q;
                    out_last_d  = 1'b1;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    rem_d       = CNT_WIDTH'(1);
                    state_d     = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (rem_q > CNT_WIDTH'(1)) begin
                        index_d      = index_q + 64'd1;
                        rem_d        = rem_q - CNT_WIDTH'(1);
                        core_start_d = 1'b1;
                        state_d      = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d      = S_IDLE;
            core_start_d = 1'b0;
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            nonce_q      <= '0;
            index_q      <= '0;
            rem_q        <= '0;
            wd_q         <= '0;
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            nonce_q      <= nonce_d;
            index_q      <= index_d;
            rem_q        <= rem_d;
            wd_q         <= wd_d;
            core_start_q <= core_start_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
            out_err_q    <= out_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign core_start = core_start_q;
    assign core_nonce = nonce_q;
    assign core_index = index_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_index  = out_index_q;
    assign out_last   = out_last_q;
    assign out_err    = out_err_q;

endmodule

// File: doc/prf_batch_scheduler.md
Name: prf_batch_scheduler

Overview:
- Sequences a single PRF evaluation core over a batch of consecutive indices for one nonce.
- Accepts a batch request (nonce, base index, count) over a valid/ready handshake.
- Issues one start pulse per index and waits for the core's done. Returns each rounded output with its index over a back-pressured output stream.
- Sits between the host/command interface and the PRF evaluate core, and provides a watchdog and an abort.

Parameters:
P, 32, PRF output modulus; OUT_WIDTH = $clog2(P)
CNT_WIDTH, 16, width of the batch count field
TIMEOUT_CYCLES, 4096, max cycles waiting for core_done; 0 disables the watchdog
TO_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous abort, any state
req_valid  in  1  batch request valid
req_ready  out  1  high only in IDLE
req_nonce  in  64  nonce for the whole batch
req_base  in  64  first index
req_count  in  CNT_WIDTH  number of evaluations
core_start  out  1  one-cycle start pulse to the core
core_nonce  out  64  registered nonce to the core
core_index  out  64  registered index to the core
core_done  in  1  core completion (level or pulse)
core_out  in  OUT_WIDTH  core result, valid while core_done is high
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  OUT_WIDTH  PRF result (0 on error)
out_index  out  64  index the result belongs to
out_last  out  1  final beat of the batch
out_err  out  1  watchdog timeout beat
busy  out  1  high whenever not in IDLE

Behaviour:
- Reset values: req_ready=1, busy=0. All of the following are 0: core_start, core_nonce, core_index, out_valid, out_data, out_index, out_last, out_err, all counters. State = IDLE.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&req_ready with req_count≠0: latch nonce, index=base, remaining=count, go to ISSUE. With req_count=0: the request is consumed, no output is produced, stay in IDLE.
  - ISSUE, one cycle: core_start=1, core_nonce/core_index driven from registers. Clear the watchdog, go to WAIT.
  - WAIT: the watchdog increments each cycle.
    - On core_done=1: capture core_out into out_data and the current index into out_index. Set out_last=(remaining==1), out_err=0, go to OUTPUT.
    - Otherwise, if TIMEOUT_CYCLES≠0 and watchdog==TIMEOUT_CYCLES-1: out_data=0, out_err=1, out_last=1, go to OUTPUT with remaining forced to 1.
    - core_done in the same cycle as the timeout wins; it is not an error.
  - OUTPUT: out_valid=1, outputs held stable until out_ready.
    - On handshake with remaining>1: index+=1 (mod 2^64), remaining-=1, go to ISSUE.
    - Otherwise go to IDLE.
- core_done is ignored outside WAIT. The core must deassert done within one cycle of core_start. WAIT begins the cycle after the start pulse, so a stale done is never sampled.
- Latency, with request accepted at cycle T:
  - core_start at T+1.
  - core_done at cycle D gives out_valid at D+1.
  - Handshake at H gives the next core_start at H+1.
  - Final handshake at H gives req_ready at H+1.
- abort=1: the next state is IDLE from any state. out_valid, core_start and busy drop the following cycle. No further beats are produced. abort has priority over all handshakes. An in-flight core result is discarded.
- Async reset mid-batch: immediate return to reset values, with no partial output.
- Index wrap: 0xFFFF_FFFF_FFFF_FFFF + 1 = 0 without error.
- req_count is unsigned; the maximum 2^CNT_WIDTH-1 must be supported.

Test Plan:
1. Nonce=0x1234, base=10, count=3; core_done 5 cycles after each start, out_ready=1 -> exactly 3 core_start pulses with index 10,11,12. out_index matches, out_last only on index 12, out_err=0, req_ready returns the cycle after the third handshake.
2. Count=0 request -> req_ready stays 1, no core_start, no out_valid; a following count=1 request is served normally.
3. Base=0xFFFF_FFFF_FFFF_FFFF, count=2, out_ready toggled 0/1 every cycle -> indices FFFF…F then 0. out_data and out_index are stable while out_valid&!out_ready. The second core_start occurs only after the first handshake.
4. TIMEOUT_CYCLES=16, core never asserts done -> out_valid with out_err=1, out_last=1, out_data=0 at cycle start+17; IDLE after handshake. A second run has done arrive exactly at the timeout cycle and must give out_err=0.
5. Abort during WAIT of a count=4 batch, and separately during OUTPUT with out_ready=0 -> no further beats, busy=0 and req_ready=1 the next cycle, and a late core_done is ignored.
6. rst_n pulsed low mid-batch -> all outputs at reset values immediately; a new batch runs correctly from index=base.
